vec3_normalize: RTL and testbench

VEC3_NORMALIZE -- requirements
Module: vec3_normalize

---
 rtl/vec3_normalize_pkg.sv | 25 ++
 rtl/inv_sqrt_seed.sv | 41 ++++
 rtl/newton_stage.sv | 37 +++
 rtl/pipe_delay.sv | 25 ++
 rtl/vec3_normalize.sv | 113 +++++++++++
 tb/tb_vec3_normalize.sv | 278 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/vec3_normalize_pkg.sv
// Shared fixed-point types and helpers for the vec3 normalize pipeline.
// Q16.16 signed fixed, vec3 struct, multiply helper and latency function.
package vec3_normalize_pkg;
  localparam int FULL_WIDTH = 32;
  localparam int FRAC_WIDTH = 16;

  typedef logic signed [FULL_WIDTH-1:0]   fixed;
  typedef logic signed [2*FULL_WIDTH-1:0] wide_t;

  typedef struct packed {
    fixed x;
    fixed y;
    fixed z;
  } vec3_t;

  localparam fixed FX_THREE = fixed'(3 << FRAC_WIDTH);

  function automatic int VEC_NORM_LATENCY(input int n);
    return 4 + 4 * n;
  endfunction

  function automatic fixed fx_mul(input fixed a, input fixed b);
    return fixed'((wide_t'(a) * wide_t'(b)) >>> FRAC_WIDTH);
  endfunction
endpackage

// File: rtl/inv_sqrt_seed.sv
// Registered 1/sqrt seed: 2^-k with k = ceil(e/2), e = msb(s) - FRAC_WIDTH.
// The seed bit position is clamped into the representable range.
module inv_sqrt_seed
  import vec3_normalize_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  fixed s_in,
  output fixed s_out,
  output fixed seed
);
  localparam int IW = $clog2(FULL_WIDTH) + 2;

  logic signed [IW-1:0] lead, e, k, pos;
  fixed seed_nx;

  // leading-one search and exponent halving
  always_comb begin
    lead = '0;
    for (int i = 0; i < FULL_WIDTH; i++) begin
      if (s_in[i]) lead = IW'(i);
    end
    e   = lead - IW'(FRAC_WIDTH);
    k   = (e + IW'(1)) >>> 1;
    pos = IW'(FRAC_WIDTH) - k;
    if (pos < IW'(0)) pos = '0;
    if (pos > IW'(FULL_WIDTH - 2)) pos = IW'(FULL_WIDTH - 2);
    seed_nx = fixed'(1) << pos;
  end

  // register seed with s kept in step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_out <= '0;
      seed  <= '0;
    end else begin
      s_out <= s_in;
      seed  <= seed_nx;
    end
  end
endmodule

// File: rtl/newton_stage.sv
// One Newton inverse-square-root step, y' = y*(3 - s*y*y)/2, 4 cycles.
// s*y is formed before the second y so the product stays near 1.
module newton_stage
  import vec3_normalize_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  fixed s_in,
  input  fixed y_in,
  output fixed s_out,
  output fixed y_out
);
  fixed s1, s2, s3;
  fixed y1, y2, y3;
  fixed sy, syy, t;

  // four-cycle step with s and y carried alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0; s2 <= '0; s3 <= '0; s_out <= '0;
      y1 <= '0; y2 <= '0; y3 <= '0; y_out <= '0;
      sy <= '0; syy <= '0; t <= '0;
    end else begin
      s1    <= s_in;
      y1    <= y_in;
      sy    <= fx_mul(s_in, y_in);
      s2    <= s1;
      y2    <= y1;
      syy   <= fx_mul(sy, y1);
      s3    <= s2;
      y3    <= y2;
      t     <= FX_THREE - syy;
      s_out <= s3;
      y_out <= fixed'((wide_t'(y3) * wide_t'(t)) >>> (FRAC_WIDTH + 1));
    end
  end
endmodule

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line used to carry side data down the pipe.
// Cleared on reset so delayed flags never leak across a reset.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];

  // shift one slot per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vec3_normalize.sv
// Pipelined vec3 normalize, latency 4 + 4*NUM_ITERS, one vector per clock.
// VEC_NORMALIZE_ZERO_GUARD_EN adds a zero-length flag and zeroed output.
module vec3_normalize
  import vec3_normalize_pkg::*;
#(
  parameter int NUM_ITERS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [3*FULL_WIDTH-1:0] v_in,
  output logic                    valid_out,
  output logic [3*FULL_WIDTH-1:0] v_out,
  output logic                    zero_out,
  output logic                    busy
);
  localparam int L = VEC_NORM_LATENCY(NUM_ITERS);

  vec3_t vin, vd, vo, v_nx;
  fixed xx, yy, zz, s_sum;
  fixed s_pipe [NUM_ITERS+1];
  fixed y_pipe [NUM_ITERS+1];
  fixed s_unused;
  logic [L-1:0] vld;

  assign vin = v_in;

  // validity shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld <= '0;
    else     vld <= {vld[L-2:0], valid_in};
  end

  assign valid_out = vld[L-1];
  assign busy      = |vld;

  // squares, then their sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xx <= '0; yy <= '0; zz <= '0; s_sum <= '0;
    end else begin
      xx    <= fx_mul(vin.x, vin.x);
      yy    <= fx_mul(vin.y, vin.y);
      zz    <= fx_mul(vin.z, vin.z);
      s_sum <= xx + yy + zz;
    end
  end

  inv_sqrt_seed u_seed (
    .clk   (clk),
    .rst   (rst),
    .s_in  (s_sum),
    .s_out (s_pipe[0]),
    .seed  (y_pipe[0])
  );

  for (genvar g = 0; g < NUM_ITERS; g++) begin : g_newton
    newton_stage u_nt (
      .clk   (clk),
      .rst   (rst),
      .s_in  (s_pipe[g]),
      .y_in  (y_pipe[g]),
      .s_out (s_pipe[g+1]),
      .y_out (y_pipe[g+1])
    );
  end

  assign s_unused = s_pipe[NUM_ITERS];

  pipe_delay #(.WIDTH(3*FULL_WIDTH), .DEPTH(L-1)) u_vd (
    .clk (clk),
    .rst (rst),
    .d   (v_in),
    .q   (vd)
  );

`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
  logic zf_d;

  pipe_delay #(.WIDTH(1), .DEPTH(L-3)) u_zf (
    .clk (clk),
    .rst (rst),
    .d   (s_sum == '0),
    .q   (zf_d)
  );

  // zero flag lands on the same beat as its vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_out <= 1'b0;
    else     zero_out <= vld[L-2] & zf_d;
  end
`else
  assign zero_out = 1'b0;
`endif

  // scale delayed components by converged 1/|v|
  always_comb begin
    v_nx.x = fx_mul(vd.x, y_pipe[NUM_ITERS]);
    v_nx.y = fx_mul(vd.y, y_pipe[NUM_ITERS]);
    v_nx.z = fx_mul(vd.z, y_pipe[NUM_ITERS]);
`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
    if (zf_d) v_nx = '0;
`endif
  end

  // output loads on valid beats only, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vo <= '0;
    else if (vld[L-2]) vo <= v_nx;
  end

  assign v_out = vo;
endmodule

// File: tb/tb_vec3_normalize.sv
// Randomized and directed bench for vec3_normalize against a real-valued model.
// Zero-vector case exercised when VEC_NORMALIZE_ZERO_GUARD_EN is defined.
module tb_vec3_normalize;
  import vec3_normalize_pkg::*;

  localparam real T12 = 1.0 / 4096.0;
  localparam real T10 = 1.0 / 1024.0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [95:0] v_in = '0;
  logic        valid_out, zero_out, busy;
  logic [95:0] v_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vo_count = 0;
  int run = 0;
  int last_run = 0;
  real cur_tol = T12;
  bit  cur_unit = 1'b0;

  int  due_q[$];
  real ex_q[$];
  real ey_q[$];
  real ez_q[$];
  real tol_q[$];
  bit  zero_q[$];
  bit  unit_q[$];

  real mo[3];
  real me[3];
  real mt;
  bit  mz, mu;
  int  md;

  vec3_normalize #(.NUM_ITERS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .v_in      (v_in),
    .valid_out (valid_out),
    .v_out     (v_out),
    .zero_out  (zero_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic real fx2r(input logic [31:0] f);
    return $itor($signed(f)) / 65536.0;
  endfunction

  function automatic logic [31:0] r2fx(input real r);
    int t;
    t = $rtoi(r * 65536.0);
    return t;
  endfunction

  function automatic real comp(input logic [95:0] v, input int i);
    return fx2r(v[(2-i)*32 +: 32]);
  endfunction

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  task automatic chk(input bit ok, input string name,
                     input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s want %s", name, got, want);
    end
  endtask

  task automatic flush();
    due_q.delete(); ex_q.delete(); ey_q.delete(); ez_q.delete();
    tol_q.delete(); zero_q.delete(); unit_q.delete();
  endtask

  task automatic pop();
    md = due_q.pop_front();
    me[0] = ex_q.pop_front();
    me[1] = ey_q.pop_front();
    me[2] = ez_q.pop_front();
    mt = tol_q.pop_front();
    mz = zero_q.pop_front();
    mu = unit_q.pop_front();
  endtask

  // reference model and per-cycle compare
  always @(negedge clk) begin
    real s, len;
    cyc++;
    if (rst) begin
      chk(!valid_out && !busy && !zero_out && v_out == '0, "reset_state",
          $sformatf("vo=%0b busy=%0b z=%0b v=%h", valid_out, busy, zero_out, v_out),
          "all zero");
      flush();
      run = 0;
    end else begin
      chk(busy == (due_q.size() != 0), "busy",
          $sformatf("%0b", busy), $sformatf("%0b", due_q.size() != 0));
      if (valid_out) begin
        vo_count++;
        run++;
        if (due_q.size() == 0) begin
          chk(1'b0, "stale_beat", "valid_out=1", "no beat");
        end else begin
          pop();
          chk(md == cyc, "latency", $sformatf("cycle %0d", cyc),
              $sformatf("cycle %0d", md));
          for (int i = 0; i < 3; i++) mo[i] = comp(v_out, i);
`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
          if (mz) begin
            chk(zero_out && v_out == '0, "zero_guard",
                $sformatf("z=%0b v=%h", zero_out, v_out), "z=1 v=0");
          end else begin
`else
          begin
`endif
            chk(!zero_out, "zero_out_low", $sformatf("%0b", zero_out), "0");
            for (int i = 0; i < 3; i++)
              chk(rabs(mo[i] - me[i]) <= mt, $sformatf("comp%0d", i),
                  $sformatf("%f", mo[i]), $sformatf("%f", me[i]));
            if (mu) begin
              len = $sqrt(mo[0]*mo[0] + mo[1]*mo[1] + mo[2]*mo[2]);
              chk(rabs(len - 1.0) <= T10, "unit_len",
                  $sformatf("%f", len), "1.0");
            end
          end
        end
      end else begin
        if (run != 0) last_run = run;
        run = 0;
        if (due_q.size() != 0 && due_q[0] <= cyc) begin
          chk(1'b0, "missing_beat", "valid_out=0",
              $sformatf("beat at cycle %0d", due_q[0]));
          pop();
        end
      end
      if (valid_in) begin
        for (int i = 0; i < 3; i++) me[i] = comp(v_in, i);
        s = me[0]*me[0] + me[1]*me[1] + me[2]*me[2];
        due_q.push_back(cyc + 24);
        zero_q.push_back(s == 0.0);
        tol_q.push_back(cur_tol);
        unit_q.push_back(cur_unit);
        if (s == 0.0) s = 1.0;
        ex_q.push_back(me[0] / $sqrt(s));
        ey_q.push_back(me[1] / $sqrt(s));
        ez_q.push_back(me[2] / $sqrt(s));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input real tol, input bit unit);
    v_in = {x, y, z};
    valid_in = 1'b1;
    cur_tol = tol;
    cur_unit = unit;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drive_rand();
    int r[3];
    real s;
    do begin
      for (int i = 0; i < 3; i++)
        r[i] = int'($urandom_range(0, 524287)) - 262144;
      s = 0.0;
      for (int i = 0; i < 3; i++) s += fx2r(r[i]) * fx2r(r[i]);
    end while (s < 1.0);
    drive(r[0], r[1], r[2], T10, 1'b1);
  endtask

  task automatic wait_vo(inout int n);
    while (!valid_out && n < 60) begin
      tick();
      n++;
    end
    if (!valid_out) chk(1'b0, "timeout", "no valid_out", "valid_out");
  endtask

  task automatic check_lit(input string name, input real x,
                           input real y, input real z);
    real e[3];
    e[0] = x; e[1] = y; e[2] = z;
    for (int i = 0; i < 3; i++)
      chk(rabs(comp(v_out, i) - e[i]) <= T12, $sformatf("%s_c%0d", name, i),
          $sformatf("%f", comp(v_out, i)), $sformatf("%f", e[i]));
  endtask

  task automatic run_single(input string name, input real x, input real y,
                            input real z, input real ex, input real ey,
                            input real ez);
    int n;
    drive(r2fx(x), r2fx(y), r2fx(z), T12, 1'b0);
    n = 1;
    wait_vo(n);
    chk(n == 24, {name, "_lat"}, $sformatf("%0d", n), "24");
    check_lit(name, ex, ey, ez);
    repeat (4) tick();
    chk(!busy, {name, "_idle"}, $sformatf("%0b", busy), "0");
  endtask

  initial begin
    int n, c0;
    repeat (3) tick();
    chk(v_out == '0 && !valid_out && !busy && !zero_out, "reset_vals",
        $sformatf("%h %0b %0b %0b", v_out, valid_out, busy, zero_out), "zeros");
    rst = 1'b0;
    run_single("v340", 3.0, 4.0, 0.0, 0.6, 0.8, 0.0);
    run_single("vm1", -1.0, -1.0, -1.0, -0.57735, -0.57735, -0.57735);
    run_single("v002", 0.0, 0.0, 2.0, 0.0, 0.0, 1.0);

    for (int i = 0; i < 10; i++) begin
      drive_rand();
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (30) tick();

    for (int i = 0; i < 30; i++) drive_rand();
    repeat (30) tick();
    chk(last_run == 30, "run30", $sformatf("%0d", last_run), "30");

`ifdef VEC_NORMALIZE_ZERO_GUARD_EN
    drive(r2fx(1.0), r2fx(2.0), r2fx(2.0), T12, 1'b0);
    drive(32'd0, 32'd0, 32'd0, T12, 1'b0);
    drive(r2fx(2.0), 32'd0, 32'd0, T12, 1'b0);
    n = 3;
    wait_vo(n);
    check_lit("g1", 0.333333, 0.666667, 0.666667);
    chk(!zero_out, "g1_z", $sformatf("%0b", zero_out), "0");
    tick();
    chk(zero_out && v_out == '0, "g2_zero",
        $sformatf("z=%0b v=%h", zero_out, v_out), "z=1 v=0");
    tick();
    check_lit("g3", 1.0, 0.0, 0.0);
    chk(!zero_out, "g3_z", $sformatf("%0b", zero_out), "0");
    repeat (5) tick();
`endif

    for (int i = 0; i < 5; i++) drive_rand();
    repeat (10) tick();
    chk(busy, "busy_inflight", $sformatf("%0b", busy), "1");
    rst = 1'b1;
    #1;
    chk(!valid_out && !busy, "reset_at_once",
        $sformatf("vo=%0b busy=%0b", valid_out, busy), "both 0");
    repeat (2) tick();
    rst = 1'b0;
    c0 = vo_count;
    repeat (40) tick();
    chk(vo_count == c0, "no_stale", $sformatf("%0d beats", vo_count - c0), "0");

    run_single("post", 0.0, 0.0, 2.0, 0.0, 0.0, 1.0);
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
